nn_mem_loader: RTL and testbench
================================

// Module: nn_mem_loader
// PURPOSE
// - Load controller upstream of mem_sys: takes a serial bit stream (valid/ready) and writes it
//   into mem_sys. Order: weight banks sel_w=0..W_BANKS-1, each W_DEPTH bits; then input bank
//   sel_x=0, X_DEPTH bits.
// - Drives mem_sys write ports directly. Hands over to the compute module via done.
// PARAMETERS
// W_ADDR_LEN  20   width of rw_address (weight address)
// X_ADDR_LEN  10   width of rw_address_x (input address)
// W_SEL_LEN   2    width of sel_w
// X_SEL_LEN   2    width of sel_x
// W_DEPTH     300  bits per weight bank
// W_BANKS     4    number of weight banks (must be <= 2**W_SEL_LEN)
// X_DEPTH     8    bits in the input bank
// PORTS
// clk           in   1           clock; all logic on posedge
// rst           in   1           asynchronous, active-low reset
// start         in   1           1-cycle pulse; begins a load when IDLE or DONE
// abort         in   1           synchronous abort; returns to IDLE with no further writes
// in_valid      in   1           stream bit valid
// in_bit        in   1           stream data bit
// in_ready      out  1           loader accepts in_bit this cycle
// write_rq_w    out  1           mem_sys weight write strobe
// write_rq_x    out  1           mem_sys input write strobe
// read_rq_w     out  1           tied 0
// read_rq_x     out  1           tied 0
// rw_address    out  W_ADDR_LEN  weight write address
// rw_address_x  out  X_ADDR_LEN  input write address
// write_data    out  1           bit to write
// sel_w         out  W_SEL_LEN   weight bank select
// sel_x         out  X_SEL_LEN   input bank select (always 0)
// busy          out  1           high in LOAD_W or LOAD_X
// done          out  1           high in DONE; held until start or abort
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; every output 0; counters 0. Reset mid-load abandons the
//   load. Bits already written stay in mem_sys.
// - FSM: IDLE -start-> LOAD_W -> LOAD_X -> DONE -start-> LOAD_W. abort in any state -> IDLE.
//   start while busy is ignored.
// - in_ready = 1 only in LOAD_W and LOAD_X, and only when abort=0. A bit is accepted on
//   accept = in_valid & in_ready.
// - Counters
//   - LOAD_W uses addr_cnt (0..W_DEPTH-1) and bank_cnt (0..W_BANKS-1).
//   - When a bit is accepted at addr_cnt=W_DEPTH-1: addr_cnt wraps to 0 and bank_cnt increments.
//   - When that happens at bank_cnt=W_BANKS-1: go to LOAD_X with addr_cnt=0.
//   - LOAD_X: when a bit is accepted at addr_cnt=X_DEPTH-1, go to DONE.
// - Write port (registered, latency 1): the cycle after each accept,
//   - the matching write_rq_* is high for exactly 1 cycle;
//   - write_data = the accepted bit;
//   - rw_address or rw_address_x = the address it was accepted at (zero-extended);
//   - sel_w = the bank it was accepted in.
// - Write port, other cycles:
//   - write_rq_* = 0.
//   - Address, data and sel hold their last values.
// - Writes are never lost or duplicated: the last bit's strobe is issued on the first DONE cycle.
// - Gaps in in_valid stall the counters; no writes occur during a gap.
// - abort on the same cycle as in_valid: the bit is not accepted (in_ready=0) and no strobe
//   follows. A strobe already registered from the previous cycle still completes.
// - start on the same cycle as abort: abort wins.
// - Entering LOAD_W from IDLE or DONE clears addr_cnt and bank_cnt.
// STRUCTURE
// - Shared package nn_pkg:
//   - state enum {IDLE, LOAD_W, LOAD_X, DONE};
//   - W_ADDR_LEN, X_ADDR_LEN, W_SEL_LEN, X_SEL_LEN, W_DEPTH, W_BANKS, X_DEPTH defaults.
// - One sub-module, nn_wrap_counter (parameters MAX and WIDTH; ports en, clr, cnt, wrap),
//   instantiated twice: addr_cnt and bank_cnt.
// - FSM and write-port register stage stay in this module.
// TESTING
// 1. Reset: rst=0 mid-LOAD_W at address 150 -> all outputs 0 immediately. After release,
//    state=IDLE and in_ready=0.
// 2. Full load: start, then 1208 valid bits back to back. Required:
//    - 1200 write_rq_w pulses, then 8 write_rq_x pulses;
//    - sel_w steps 0,1,2,3 at addresses 0..299;
//    - rw_address_x steps 0..7;
//    - done=1 on the cycle of the last strobe;
//    - mem_sys readback matches the stream.
// 3. Bubbles: random in_valid gaps -> same write sequence as test 2, with no strobes during gaps.
// 4. Bank boundary: bit 299 of bank 0 -> write at (sel_w=0, addr 299); the next bit goes to
//    (sel_w=1, addr 0).
// 5. Abort: abort at bank 2, address 17, with in_valid=1. Required:
//    - that bit is not written;
//    - state=IDLE next cycle;
//    - a following start resumes writing from (sel_w=0, addr 0).
// 6. start ignored while busy. From DONE, start -> done=0 and a second full load is correct.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and default geometry for the nn memory loader and its helpers.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        DONE
    } state_t;

    localparam int W_ADDR_LEN = 20;
    localparam int X_ADDR_LEN = 10;
    localparam int W_SEL_LEN  = 2;
    localparam int X_SEL_LEN  = 2;
    localparam int W_DEPTH    = 300;
    localparam int W_BANKS    = 4;
    localparam int X_DEPTH    = 8;

endpackage

// File: rtl/nn_wrap_counter.sv
// Modulo-MAX up counter with synchronous clear; wrap flags the enabled terminal step.
module nn_wrap_counter #(
    parameter int MAX   = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    assign wrap = en && (cnt == WIDTH'(MAX - 1));

    // clr takes priority so a fresh load always starts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nn_mem_loader.sv
// Streams serial bits into mem_sys: weight banks first, then the input bank, then signals done.
module nn_mem_loader
    import nn_pkg::*;
#(
    parameter int W_ADDR_LEN = nn_pkg::W_ADDR_LEN,
    parameter int X_ADDR_LEN = nn_pkg::X_ADDR_LEN,
    parameter int W_SEL_LEN  = nn_pkg::W_SEL_LEN,
    parameter int X_SEL_LEN  = nn_pkg::X_SEL_LEN,
    parameter int W_DEPTH    = nn_pkg::W_DEPTH,
    parameter int W_BANKS    = nn_pkg::W_BANKS,
    parameter int X_DEPTH    = nn_pkg::X_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  in_ready,
    output logic                  write_rq_w,
    output logic                  write_rq_x,
    output logic                  read_rq_w,
    output logic                  read_rq_x,
    output logic [W_ADDR_LEN-1:0] rw_address,
    output logic [X_ADDR_LEN-1:0] rw_address_x,
    output logic                  write_data,
    output logic [W_SEL_LEN-1:0]  sel_w,
    output logic [X_SEL_LEN-1:0]  sel_x,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(W_DEPTH);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     addr_cnt;
    logic [W_SEL_LEN-1:0] bank_cnt;
    logic                 addr_wrap;
    logic                 bank_wrap;
    logic                 load_w;
    logic                 load_x;
    logic                 accept;
    logic                 start_load;
    logic                 x_last;

    assign load_w     = (state == LOAD_W);
    assign load_x     = (state == LOAD_X);
    assign in_ready   = (load_w || load_x) && !abort;
    assign accept     = in_valid && in_ready;
    assign start_load = start && !abort && ((state == IDLE) || (state == DONE));
    assign x_last     = accept && load_x && (addr_cnt == CNT_W'(X_DEPTH - 1));

    assign busy      = load_w || load_x;
    assign done      = (state == DONE);
    assign read_rq_w = 1'b0;
    assign read_rq_x = 1'b0;
    assign sel_x     = '0;

    // The address counter also serves LOAD_X; it is cleared once the input bank completes
    nn_wrap_counter #(
        .MAX   (W_DEPTH),
        .WIDTH (CNT_W)
    ) u_addr_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .clr  (start_load || abort || x_last),
        .cnt  (addr_cnt),
        .wrap (addr_wrap)
    );

    nn_wrap_counter #(
        .MAX   (W_BANKS),
        .WIDTH (W_SEL_LEN)
    ) u_bank_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (load_w && addr_wrap),
        .clr  (start_load || abort),
        .cnt  (bank_cnt),
        .wrap (bank_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_next = LOAD_W;
                LOAD_W:     if (bank_wrap) state_next = LOAD_X;
                LOAD_X:     if (x_last) state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    // One-cycle registered write port; address, data and select hold between strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_rq_w   <= 1'b0;
            write_rq_x   <= 1'b0;
            write_data   <= 1'b0;
            rw_address   <= '0;
            rw_address_x <= '0;
            sel_w        <= '0;
        end else begin
            write_rq_w <= accept && load_w;
            write_rq_x <= accept && load_x;
            if (accept) begin
                write_data <= in_bit;
                if (load_w) begin
                    rw_address <= W_ADDR_LEN'(addr_cnt);
                    sel_w      <= bank_cnt;
                end else begin
                    rw_address_x <= X_ADDR_LEN'(addr_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_nn_mem_loader.sv
// Scoreboard bench for nn_mem_loader: a bench-side load model predicts every write strobe.
module tb_nn_mem_loader;

    localparam int WD    = 300;
    localparam int NB    = 4;
    localparam int XD    = 8;
    localparam int NW    = NB * WD;
    localparam int TOTAL = NW + XD;

    typedef struct {
        bit     is_x;
        int     sel;
        int     addr;
        bit     data;
        longint due;
        bit     last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_ready;
    logic        write_rq_w;
    logic        write_rq_x;
    logic        read_rq_w;
    logic        read_rq_x;
    logic [19:0] rw_address;
    logic [9:0]  rw_address_x;
    logic        write_data;
    logic [1:0]  sel_w;
    logic [1:0]  sel_x;
    logic        busy;
    logic        done;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     m_state = 0;
    int     m_idx = 0;
    int     w_pulses = 0;
    int     x_pulses = 0;
    bit     stream[TOTAL];
    bit     mem_w[NB][WD];
    bit     mem_x[XD];
    bit     wr_flag_w[NB][WD];

    nn_mem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .in_ready     (in_ready),
        .write_rq_w   (write_rq_w),
        .write_rq_x   (write_rq_x),
        .read_rq_w    (read_rq_w),
        .read_rq_x    (read_rq_x),
        .rw_address   (rw_address),
        .rw_address_x (rw_address_x),
        .write_data   (write_data),
        .sel_w        (sel_w),
        .sel_x        (sel_x),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every negedge: the strobe must match the scoreboard head exactly, and mem_sys is mirrored
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] es;
        es = 32'd0;
        if (sb.size() > 0 && sb[0].due == cyc) es = sb[0].is_x ? 32'd1 : 32'd2;
        check_output("strobe", {30'd0, write_rq_w, write_rq_x}, es);
        if (write_rq_w) begin
            w_pulses++;
            if (rw_address < 20'(WD)) begin
                mem_w[sel_w][rw_address] = write_data;
                wr_flag_w[sel_w][rw_address] = 1'b1;
            end
        end
        if (write_rq_x) begin
            x_pulses++;
            if (rw_address_x < 10'(XD)) mem_x[rw_address_x] = write_data;
        end
        if (es != 0) begin
            e = sb.pop_front();
            check_output("wdata", {31'd0, write_data}, {31'd0, e.data});
            if (e.is_x) begin
                check_output("addr_x", {22'd0, rw_address_x}, e.addr);
            end else begin
                check_output("addr_w", {12'd0, rw_address}, e.addr);
                check_output("sel_w", {30'd0, sel_w}, e.sel);
            end
            check_output("done_at_strobe", {31'd0, done}, {31'd0, e.last});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit v, input bit b, input bit s, input bit a);
        exp_t e;
        bit   acc;
        in_valid = v;
        in_bit   = b;
        start    = s;
        abort    = a;
        #1;
        check_output("in_ready", {31'd0, in_ready}, {31'd0, (m_state == 1 || m_state == 2) && !a});
        check_output("busy", {31'd0, busy}, {31'd0, m_state == 1 || m_state == 2});
        check_output("done", {31'd0, done}, {31'd0, m_state == 3});
        acc = v && (m_state == 1 || m_state == 2) && !a;
        if (a) begin
            m_state = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (s) begin
                m_state = 1;
                m_idx   = 0;
            end
        end else if (acc) begin
            e.is_x = (m_idx >= NW);
            e.sel  = e.is_x ? 0 : m_idx / WD;
            e.addr = e.is_x ? m_idx - NW : m_idx % WD;
            e.data = b;
            e.due  = cyc + 1;
            e.last = (m_idx == TOTAL - 1);
            sb.push_back(e);
            m_idx++;
            if (m_idx == NW) m_state = 2;
            else if (m_idx == TOTAL) m_state = 3;
        end
        tick();
    endtask

    task automatic prepare_load();
        for (int i = 0; i < TOTAL; i++) stream[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NW; i++) begin
            mem_w[i / WD][i % WD] = ~stream[i];
            wr_flag_w[i / WD][i % WD] = 1'b0;
        end
        for (int i = 0; i < XD; i++) mem_x[i] = ~stream[NW + i];
        w_pulses = 0;
        x_pulses = 0;
    endtask

    task automatic run_load(input bit bubbles, input bit noisy_start);
        bit v;
        bit s;
        prepare_load();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6000 && m_state != 3; i++) begin
            v = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            s = noisy_start && ($urandom_range(0, 39) == 0);
            apply_stimulus(v, stream[m_idx], s, 1'b0);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("w_pulses", w_pulses, NW);
        check_output("x_pulses", x_pulses, XD);
        for (int i = 0; i < NW; i++)
            check_output("readback_w", {31'd0, mem_w[i / WD][i % WD]}, {31'd0, stream[i]});
        for (int i = 0; i < XD; i++)
            check_output("readback_x", {31'd0, mem_x[i]}, {31'd0, stream[NW + i]});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy_done", {30'd0, busy, done}, 32'd0);
        rst = 1'b1;
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during weight load");
        prepare_load();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 150; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        sb.delete();
        m_state = 0;
        m_idx   = 0;
        rst = 1'b0;
        #1;
        check_output("rst_addr", {12'd0, rw_address}, 32'd0);
        check_output("rst_ctrl", {10'd0, in_ready, write_rq_w, write_rq_x, read_rq_w, read_rq_x,
                                  write_data, sel_w, sel_x, busy, done, rw_address_x}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] full load from idle");
        run_load(1'b0, 1'b0);
        $display("[TB] reload from done with start pulses while busy");
        run_load(1'b0, 1'b1);
        $display("[TB] load with valid gaps");
        run_load(1'b1, 1'b0);

        $display("[TB] bank boundary and abort");
        prepare_load();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) apply_stimulus(1'b1, stream[i], (i == 100), 1'b0);
        check_output("edge_strobe", {31'd0, write_rq_w}, 32'd1);
        check_output("edge_sel", {30'd0, sel_w}, 32'd0);
        check_output("edge_addr", {12'd0, rw_address}, 32'd299);
        apply_stimulus(1'b1, stream[300], 1'b0, 1'b0);
        check_output("next_sel", {30'd0, sel_w}, 32'd1);
        check_output("next_addr", {12'd0, rw_address}, 32'd0);
        for (int i = 301; i < 2 * WD + 17; i++) apply_stimulus(1'b1, stream[i], 1'b0, 1'b0);
        apply_stimulus(1'b1, stream[2 * WD + 17], 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("abort_no_write", {31'd0, wr_flag_w[2][17]}, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, stream[i], 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("resume_first", {31'd0, mem_w[0][0]}, {31'd0, stream[0]});
        check_output("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
